// File: rtl/decode_stage_hz.sv
// -----------------------------------------------------------------------------
// decode_stage_hz
//   Instruction decode stage. Holds the IF/ID pipeline register (stall/flush),
//   the register file with optional same-cycle write-back bypass, branch-operand
//   forwarding from M and WB, load-use / branch hazard detection and beq/bne
//   resolution in ID.
//
// Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   instr_if, pc_plus4_if,        fetch-side instruction, PC+4, valid
//   valid_if
//   flush_i                       external IF/ID flush (exception/redirect)
//   branch_i, branch_ne_i         control-unit branch decode of ID instruction
//   ex_*, m_*                     downstream destination/writeback/load flags
//   alu_out_im                    M-stage ALU result (branch forwarding)
//   wb_dst_i, wb_regwrite_i,      register-file write port
//   res_iwb
//   op_o, funct_o, rs_o, rt_o,    decoded instruction fields
//   rd_o
//   rd1_o, rd2_o                  register read data for rs/rt
//   sign_imm_o, se_shamt_o        sign-extended immediate / shift amount
//   pc_branch_o                   branch target
//   branch_taken_o                branch resolved taken this cycle
//   stall_o                       hold PC and IF/ID, bubble into EX
//   valid_o                       ID instruction valid and not stalled
// -----------------------------------------------------------------------------
module decode_stage_hz #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit BYPASS_WB = 1'b1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     instr_if,
    input  logic [XLEN-1:0] pc_plus4_if,
    input  logic            valid_if,
    input  logic            flush_i,
    input  logic            branch_i,
    input  logic            branch_ne_i,
    input  logic [AW-1:0]   ex_dst_i,
    input  logic            ex_regwrite_i,
    input  logic            ex_memtoreg_i,
    input  logic [AW-1:0]   m_dst_i,
    input  logic            m_regwrite_i,
    input  logic            m_memtoreg_i,
    input  logic [XLEN-1:0] alu_out_im,
    input  logic [AW-1:0]   wb_dst_i,
    input  logic            wb_regwrite_i,
    input  logic [XLEN-1:0] res_iwb,
    output logic [5:0]      op_o,
    output logic [5:0]      funct_o,
    output logic [AW-1:0]   rs_o,
    output logic [AW-1:0]   rt_o,
    output logic [AW-1:0]   rd_o,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] sign_imm_o,
    output logic [XLEN-1:0] se_shamt_o,
    output logic [XLEN-1:0] pc_branch_o,
    output logic            branch_taken_o,
    output logic            stall_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc4_q;
    logic            valid_q;
    logic [XLEN-1:0] rf_q [NREGS];

    logic            flush_ifid;
    logic            wb_wr;
    logic            ex_hit;
    logic            m_hit;
    logic            lw_stall;
    logic            br_stall;
    logic            eq;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    // A taken branch squashes the wrong-path instruction fetched behind it.
    assign flush_ifid = flush_i | branch_taken_o;

    // IF/ID register: flush beats stall, stall beats load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_ifid) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!stall_o) begin
            instr_q <= instr_if;
            pc4_q   <= pc_plus4_if;
            valid_q <= valid_if;
        end
    end

    assign wb_wr = wb_regwrite_i && (wb_dst_i != '0);

    // r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_wr) begin
            rf_q[wb_dst_i] <= res_iwb;
        end
    end

    assign op_o    = instr_q[31:26];
    assign funct_o = instr_q[5:0];
    assign rs_o    = instr_q[21 +: AW];
    assign rt_o    = instr_q[16 +: AW];
    assign rd_o    = instr_q[11 +: AW];

    assign sign_imm_o  = XLEN'($signed(instr_q[15:0]));
    assign se_shamt_o  = XLEN'($signed(instr_q[10:6]));
    assign pc_branch_o = pc4_q + (sign_imm_o << 2);

    // Read ports return zero for r0 and while the ID slot holds a bubble.
    always_comb begin
        rd1_o = '0;
        if (valid_q && (rs_o != '0)) begin
            if (BYPASS_WB && wb_wr && (wb_dst_i == rs_o)) rd1_o = res_iwb;
            else                                          rd1_o = rf_q[rs_o];
        end
    end

    always_comb begin
        rd2_o = '0;
        if (valid_q && (rt_o != '0)) begin
            if (BYPASS_WB && wb_wr && (wb_dst_i == rt_o)) rd2_o = res_iwb;
            else                                          rd2_o = rf_q[rt_o];
        end
    end

    // Branch comparator operands. A load in M has no data yet, so it is not
    // a forwarding source; the hazard unit stalls on it instead.
    always_comb begin
        fwd_a = rd1_o;
        if (rs_o != '0) begin
            if (m_regwrite_i && !m_memtoreg_i && (m_dst_i == rs_o)) fwd_a = alu_out_im;
            else if (wb_regwrite_i && (wb_dst_i == rs_o))         fwd_a = res_iwb;
        end
    end

    always_comb begin
        fwd_b = rd2_o;
        if (rt_o != '0) begin
            if (m_regwrite_i && !m_memtoreg_i && (m_dst_i == rt_o)) fwd_b = alu_out_im;
            else if (wb_regwrite_i && (wb_dst_i == rt_o))         fwd_b = res_iwb;
        end
    end

    assign ex_hit = (ex_dst_i != '0) && ((ex_dst_i == rs_o) || (ex_dst_i == rt_o));
    assign m_hit  = (m_dst_i  != '0) && ((m_dst_i  == rs_o) || (m_dst_i  == rt_o));

    assign lw_stall = ex_memtoreg_i && ex_hit;
    assign br_stall = branch_i && ((ex_regwrite_i && ex_hit) || (m_memtoreg_i && m_hit));
    assign stall_o  = valid_q && (lw_stall || br_stall);

    assign eq             = (fwd_a == fwd_b);
    assign branch_taken_o = valid_q && branch_i && !stall_o && (branch_ne_i ? !eq : eq);
    assign valid_o        = valid_q && !stall_o;

endmodule
